// File: rtl/multi_sync_filter.sv
// Purpose : per-channel async-input synchroniser, stability filter and edge detector.
// Latency : STAGES edges to sync_out, then FILTER_CYCLES qualifying ticks to level_out.
// Backpressure: none; free-running, filter_tick only gates counter advance.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset
//   filter_tick  counter qualify strobe (tie 1 to count every clk)
//   async_in     WIDTH asynchronous inputs
//   sync_out     raw synchronised value (last sync stage)
//   level_out    filtered, debounced level
//   rise_pulse   one-clk pulse when a level_out bit goes 0->1
//   fall_pulse   one-clk pulse when a level_out bit goes 1->0
module multi_sync_filter #(
    parameter int               WIDTH         = 4,
    parameter int               STAGES        = 2,
    parameter int               FILTER_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             filter_tick,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    localparam int               CNT_W    = $clog2(FILTER_CYCLES + 1);
    // Count value on which the next qualifying tick commits the new level.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] sync_d [STAGES];
    logic [CNT_W-1:0] cnt_q  [WIDTH];
    logic [CNT_W-1:0] cnt_d  [WIDTH];
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;

    assign sync_out   = sync_q[STAGES-1];
    assign level_out  = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

    // Plain shift chain: nothing combinational between stages so each
    // stage gets a full cycle to resolve metastability.
    always_comb begin
        sync_d[0] = async_in;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int c = 0; c < WIDTH; c++) begin
            cnt_d[c] = cnt_q[c];
            if (sync_out[c] == level_q[c]) begin
                // Any agreement discards partial progress, so glitches never
                // accumulate into a level change.
                cnt_d[c] = '0;
            end else if (filter_tick) begin
                if (cnt_q[c] == CNT_LAST) begin
                    level_d[c] = sync_out[c];
                    cnt_d[c]   = '0;
                    rise_d[c]  = sync_out[c];
                    fall_d[c]  = ~sync_out[c];
                end else begin
                    cnt_d[c] = cnt_q[c] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= RESET_VALUE;
            end
            for (int c = 0; c < WIDTH; c++) begin
                cnt_q[c] <= '0;
            end
            level_q <= RESET_VALUE;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            for (int c = 0; c < WIDTH; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

endmodule
